aes_ctr_sequencer: RTL and testbench

AES_CTR_SEQUENCER -- requirements
Module: aes_ctr_sequencer

---
 rtl/aes_ctr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer: drives an external AES-128 encrypt core over successive
// counter blocks and queues each result as keystream in a small FIFO.
module aes_ctr_sequencer #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic [15:0]  cfg_nblk,
    output logic         busy,
    output logic         done,
    output logic [15:0]  blk_cnt,
    output logic         ks_valid,
    output logic [127:0] ks_data,
    input  logic         ks_ready,
    output logic         core_nrst,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_rdy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STORE, DRAIN} state_t;

    state_t           state_q;
    logic [127:0]     key_q;
    logic [127:0]     ctr_q;
    logic [127:0]     ctr_inc_d;
    logic [15:0]      rem_q;
    logic [15:0]      blk_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             core_nrst_q;
    logic             load_cnt_q;

    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Push depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign push       = (state_q == STORE) && !fifo_full;
    assign pop        = !fifo_empty && ks_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Only the low CNT_W bits of the counter block roll over; the rest stays fixed.
    generate
        if (CNT_W < 128) begin : g_ctr_split
            assign ctr_inc_d = {ctr_q[127:CNT_W], ctr_q[CNT_W-1:0] + CNT_W'(1)};
        end else begin : g_ctr_full
            assign ctr_inc_d = ctr_q + 128'd1;
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= core_out;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            key_q       <= '0;
            ctr_q       <= '0;
            rem_q       <= '0;
            blk_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_nrst_q <= 1'b0;
            load_cnt_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else if (abort) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_nrst_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case (state_q)
                IDLE: begin
                    core_nrst_q <= 1'b0;
                    if (start) begin
                        key_q      <= cfg_key;
                        ctr_q      <= cfg_iv;
                        rem_q      <= cfg_nblk;
                        blk_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        load_cnt_q <= 1'b0;
                        state_q    <= (cfg_nblk == 16'd0) ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (load_cnt_q) begin
                        core_nrst_q <= 1'b1;
                        state_q     <= RUN;
                    end else begin
                        load_cnt_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_rdy) begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    if (!fifo_full) begin
                        blk_cnt_q   <= blk_cnt_q + 16'd1;
                        rem_q       <= rem_q - 16'd1;
                        ctr_q       <= ctr_inc_d;
                        core_nrst_q <= 1'b0;
                        load_cnt_q  <= 1'b0;
                        state_q     <= (rem_q != 16'd1) ? LOAD : DRAIN;
                    end
                end
                DRAIN: begin
                    core_nrst_q <= 1'b0;
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign blk_cnt   = blk_cnt_q;
    assign ks_valid  = !fifo_empty;
    assign ks_data   = fifo_mem[rd_ptr_q];
    assign core_nrst = core_nrst_q;
    assign core_in   = ctr_q;
    assign core_key  = key_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Randomized bench for aes_ctr_sequencer: a stand-in encrypt core with random
// latency, a random-ready consumer, and a keystream model built from CTR rules.
module tb_aes_ctr_sequencer;
    localparam logic [127:0] KAT_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic         start    = 1'b0;
    logic         abort    = 1'b0;
    logic [127:0] cfg_key  = '0;
    logic [127:0] cfg_iv   = '0;
    logic [15:0]  cfg_nblk = '0;
    logic         ks_ready = 1'b0;
    logic [127:0] core_out = '0;
    logic         core_rdy = 1'b0;
    logic         busy;
    logic         done;
    logic [15:0]  blk_cnt;
    logic         ks_valid;
    logic [127:0] ks_data;
    logic         core_nrst;
    logic [127:0] core_in;
    logic [127:0] core_key;

    aes_ctr_sequencer #(.FIFO_DEPTH(2), .CNT_W(32)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (start),
        .abort    (abort),
        .cfg_key  (cfg_key),
        .cfg_iv   (cfg_iv),
        .cfg_nblk (cfg_nblk),
        .busy     (busy),
        .done     (done),
        .blk_cnt  (blk_cnt),
        .ks_valid (ks_valid),
        .ks_data  (ks_data),
        .ks_ready (ks_ready),
        .core_nrst(core_nrst),
        .core_in  (core_in),
        .core_key (core_key),
        .core_out (core_out),
        .core_rdy (core_rdy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q[$];
    logic [127:0] core_in_log[$];
    logic [127:0] core_key_log[$];
    logic [127:0] run_key;
    logic [127:0] run_iv;
    int           run_n;
    logic [127:0] last_pop;
    int           lat_min = 1;
    int           lat_max = 5;
    int           lat_left;
    bit           launched = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Stand-in cipher: the real AES answer for the known-answer vector, a keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == KAT_K && p == KAT_P) return KAT_C;
        return {p[95:0], p[127:96]} ^ k ^ {4{p[31:0] * 32'h9E3779B1}};
    endfunction

    function automatic logic [127:0] ctr_at(input logic [127:0] iv, input int i);
        logic [31:0] lo;
        lo = iv[31:0] + 32'(i);
        return {iv[127:32], lo};
    endfunction

    // Core model: garbage on rdy/out while held in restart, result after a random latency.
    always @(negedge wb_clk_i) begin
        if (core_nrst !== 1'b1) begin
            launched = 1'b0;
            core_rdy = ($urandom_range(0, 3) == 0);
            core_out = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else if (!launched) begin
            launched = 1'b1;
            lat_left = $urandom_range(lat_min, lat_max);
            core_in_log.push_back(core_in);
            core_key_log.push_back(core_key);
            core_rdy = 1'b0;
        end else if (lat_left > 1) begin
            lat_left--;
        end else begin
            core_rdy = 1'b1;
            core_out = core_fn(core_key, core_in);
        end
    end

    task automatic step(input int ready_pct);
        ks_ready = ($urandom_range(0, 99) < ready_pct);
        if (ks_valid && ks_ready) begin
            last_pop = ks_data;
            if (exp_q.size() == 0) check_eq("ks_unexpected_word", {127'd0, ks_valid}, 128'd0);
            else                   check_eq("ks_data_order", ks_data, exp_q.pop_front());
        end
        @(negedge wb_clk_i);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"},      busy,      0);
        check_eq({tag, "_done"},      done,      0);
        check_eq({tag, "_ks_valid"},  ks_valid,  0);
        check_eq({tag, "_blk_cnt"},   blk_cnt,   0);
        check_eq({tag, "_core_nrst"}, core_nrst, 0);
        check_eq({tag, "_core_in"},   core_in,   0);
        check_eq({tag, "_core_key"},  core_key,  0);
    endtask

    task automatic launch(input logic [127:0] k, input logic [127:0] iv, input int n);
        run_key = k;
        run_iv  = iv;
        run_n   = n;
        exp_q.delete();
        core_in_log.delete();
        core_key_log.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(core_fn(k, ctr_at(iv, i)));
        cfg_key  = k;
        cfg_iv   = iv;
        cfg_nblk = 16'(n);
        start    = 1'b1;
        @(negedge wb_clk_i);
        start    = 1'b0;
        cfg_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
        cfg_iv   = {$urandom(), $urandom(), $urandom(), $urandom()};
        cfg_nblk = 16'($urandom_range(1, 20));
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic finish_run(input int ready_pct);
        int cyc;
        bit seen;
        int nl;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 3000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (run_n == 0) begin
                check_eq("nblk0_core_nrst", core_nrst, 0);
                check_eq("nblk0_ks_valid",  ks_valid,  0);
            end
            step(ready_pct);
            cyc++;
        end
        check_eq("done_seen", seen, 1);
        if (run_n == 0) check_eq("nblk0_done_within_2", (cyc <= 2), 1);
        check_eq("done_busy_low", busy, 0);
        check_eq("blk_cnt_final", blk_cnt, run_n);
        check_eq("ks_words_missing", exp_q.size(), 0);
        check_eq("core_launches", core_in_log.size(), run_n);
        nl = (core_in_log.size() < run_n) ? core_in_log.size() : run_n;
        for (int i = 0; i < nl; i++) begin
            check_eq("core_in_ctr", core_in_log[i], ctr_at(run_iv, i));
            check_eq("core_key",    core_key_log[i], run_key);
        end
        step(ready_pct);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
        $display("run n=%0d iv=%h ready=%0d%% cycles=%0d blk_cnt=%0d", run_n, run_iv, ready_pct, cyc, blk_cnt);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] iv;
        int           budget;

        repeat (3) @(negedge wb_clk_i);
        check_reset_state("reset");
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Known-answer vector through the full flow
        launch(KAT_K, KAT_P, 1);
        finish_run(100);
        check_eq("kat_word", last_pop, KAT_C);

        // Low counter field wraps, upper 96 bits untouched
        iv = {{12{8'hA5}}, 32'hFFFFFFFF};
        launch(rand128(), iv, 2);
        finish_run(70);
        if (core_in_log.size() >= 2) check_eq("wrap_core_in", core_in_log[1], {{12{8'hA5}}, 32'h00000000});
        else                         check_eq("wrap_launches", core_in_log.size(), 2);

        // Consumer stalled: FIFO fills at 2 and the sequencer parks in STORE
        launch(rand128(), rand128(), 4);
        repeat (60) step(0);
        check_eq("stall_blk_cnt",   blk_cnt,   2);
        check_eq("stall_busy",      busy,      1);
        check_eq("stall_ks_valid",  ks_valid,  1);
        check_eq("stall_core_nrst", core_nrst, 1);
        finish_run(100);

        // Zero-block run
        launch(rand128(), rand128(), 0);
        finish_run(100);

        // Random runs, some starting near the counter wrap
        for (int r = 0; r < 6; r++) begin
            iv = rand128();
            if (r % 2 == 1) iv[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 4));
            launch(rand128(), iv, $urandom_range(1, 9));
            finish_run((r % 3 == 0) ? 100 : ((r % 3 == 1) ? 50 : 20));
        end

        // Abort while the core works on block 3 of 8
        lat_min = 6;
        lat_max = 6;
        launch(rand128(), rand128(), 8);
        budget = 0;
        while (!(core_in_log.size() == 3 && core_nrst && !core_rdy) && budget < 300) begin
            step(0);
            budget++;
        end
        check_eq("abort_reached_block3", (budget < 300), 1);
        check_eq("pre_abort_ks_valid", ks_valid, 1);
        abort = 1'b1;
        step(0);
        abort = 1'b0;
        check_eq("abort_busy",      busy,      0);
        check_eq("abort_ks_valid",  ks_valid,  0);
        check_eq("abort_core_nrst", core_nrst, 0);
        check_eq("abort_blk_cnt",   blk_cnt,   2);
        for (int i = 0; i < 5; i++) begin
            check_eq("abort_no_done", done, 0);
            step(100);
        end
        lat_min = 1;
        lat_max = 5;
        launch(rand128(), rand128(), 5);
        finish_run(60);

        // Start while busy is ignored; reset during a STORE stall
        launch(rand128(), rand128(), 4);
        repeat (60) step(0);
        start = 1'b1;
        step(0);
        start = 1'b0;
        check_eq("busy_start_blk_cnt", blk_cnt, 2);
        check_eq("busy_start_busy",    busy,    1);
        repeat (3) step(0);
        check_eq("busy_start_still_store", core_nrst, 1);
        wb_rst_i = 1'b1;
        step(0);
        wb_rst_i = 1'b0;
        check_reset_state("midrun_reset");
        for (int i = 0; i < 4; i++) begin
            check_eq("reset_no_done", done, 0);
            step(100);
        end
        launch(rand128(), rand128(), 3);
        finish_run(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
